// File: rtl/branch_tag_ctrl.sv
// Speculative branch-tag allocator: circular pool of BR_NUM tags, in-order free, full flush on mispredict.
// Optional: define BTAG_FREE_BYPASS_EN to let a full pool grant in the same cycle as a valid free.
module branch_tag_ctrl #(
    parameter int unsigned BR_NUM = 4,
    parameter int unsigned PTR_W  = $clog2(BR_NUM),
    parameter int unsigned CNT_W  = $clog2(BR_NUM + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              allocReq,
    input  logic              stall,
    output logic              allocGnt,
    output logic [PTR_W-1:0]  allocIdx,
    output logic [BR_NUM-1:0] depMask,
    input  logic              freeEn,
    input  logic [PTR_W-1:0]  freeIdx,
    input  logic              misTaken,
    output logic [BR_NUM-1:0] liveMask,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              orderErr
);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BR_NUM-1:0] live_q, live_d;
    logic              order_err_q, order_err_d;
    logic              free_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BR_NUM - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CNT_W'(BR_NUM));
    assign free_ok  = freeEn && (count_q != '0) && (freeIdx == head_q);
    assign allocIdx = tail_q;
    assign depMask  = live_q;
    assign liveMask = live_q;
    assign count    = count_q;
    assign orderErr = order_err_q;

`ifdef BTAG_FREE_BYPASS_EN
    // When full, head == tail, so the slot being freed is the one handed out.
    assign allocGnt = allocReq && !stall && !misTaken && (!full || free_ok);
`else
    assign allocGnt = allocReq && !stall && !misTaken && !full;
`endif

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        live_d      = live_q;
        order_err_d = order_err_q;
        if (misTaken) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            live_d  = '0;
        end else begin
            if (free_ok) begin
                live_d[head_q] = 1'b0;
                head_d         = ptr_inc(head_q);
            end else if (freeEn) begin
                order_err_d = 1'b1;
            end
            // Set after clear so a same-slot free+alloc leaves the slot live.
            if (allocGnt) begin
                live_d[tail_q] = 1'b1;
                tail_d         = ptr_inc(tail_q);
            end
            if (allocGnt && !free_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (free_ok && !allocGnt) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            live_q      <= '0;
            order_err_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            live_q      <= live_d;
            order_err_q <= order_err_d;
        end
    end

endmodule
